mlp_seq_engine: RTL

MLP_SEQ_ENGINE -- requirements
Module: mlp_seq_engine

---
 rtl/mlp_pkg.sv | 31 +++
 rtl/mlp_mac.sv | 41 ++++
 rtl/mlp_seq_engine.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared types, default sizing and helpers for the sequential MLP inference engine.
package mlp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StL0,
        StL1,
        StDone
    } state_e;

    localparam int unsigned DEF_NUM_IN    = 4;
    localparam int unsigned DEF_NUM_HID   = 3;
    localparam int unsigned DEF_NUM_OUT   = 3;
    localparam int unsigned DEF_WIDTH_A   = 4;
    localparam int unsigned DEF_WIDTH_W   = 8;
    localparam int unsigned DEF_WIDTH_B0  = 12;
    localparam int unsigned DEF_WIDTH_B1  = 16;
    localparam int unsigned DEF_WIDTH_H   = 8;
    localparam int unsigned DEF_HID_SHIFT = 3;
    localparam int unsigned DEF_ACC_W     = 24;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mlp_mac.sv
// Single shared multiply-accumulate: unsigned activation times signed weight,
// accumulated into a registered signed sum that can be reloaded with a bias.
module mlp_mac #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned W_W   = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] load_val,
    input  logic        [A_W-1:0]   a,
    input  logic signed [W_W-1:0]   w,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] prod;

    always_comb begin
        a_ext = {{(ACC_W - A_W){1'b0}}, a};
        w_ext = {{(ACC_W - W_W){w[W_W-1]}}, w};
        prod  = a_ext * w_ext;
        sum   = acc_q + prod;
    end

    // Load has priority so a neuron's last product and the next bias share a cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= load_val;
        end else if (en) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/mlp_seq_engine.sv
// Two-layer MLP classifier evaluated one product per cycle through a shared MAC,
// with rectified/saturated hidden layer and incremental argmax over the outputs.
module mlp_seq_engine
    import mlp_pkg::*;
#(
    parameter int unsigned NUM_IN    = DEF_NUM_IN,
    parameter int unsigned NUM_HID   = DEF_NUM_HID,
    parameter int unsigned NUM_OUT   = DEF_NUM_OUT,
    parameter int unsigned WIDTH_A   = DEF_WIDTH_A,
    parameter int unsigned WIDTH_W   = DEF_WIDTH_W,
    parameter int unsigned WIDTH_B0  = DEF_WIDTH_B0,
    parameter int unsigned WIDTH_B1  = DEF_WIDTH_B1,
    parameter int unsigned WIDTH_H   = DEF_WIDTH_H,
    parameter int unsigned HID_SHIFT = DEF_HID_SHIFT,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    localparam int unsigned NUM_W    = NUM_IN * NUM_HID + NUM_HID * NUM_OUT,
    localparam int unsigned OUTWIDTH = (clog2(NUM_OUT) > 1) ? clog2(NUM_OUT) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_IN*WIDTH_A-1:0]                     inp,
    input  logic [NUM_W*WIDTH_W-1:0]                      weights,
    input  logic [NUM_HID*WIDTH_B0+NUM_OUT*WIDTH_B1-1:0]  biases,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [OUTWIDTH-1:0]                           out,
    output logic signed [ACC_W-1:0]                       out_score
);

    localparam int unsigned MAXN   = (NUM_IN > NUM_HID) ?
                                     ((NUM_IN > NUM_OUT) ? NUM_IN : NUM_OUT) :
                                     ((NUM_HID > NUM_OUT) ? NUM_HID : NUM_OUT);
    localparam int unsigned CNT_W  = (clog2(MAXN) > 1) ? clog2(MAXN) : 1;
    localparam int unsigned MAC_AW = (WIDTH_A > WIDTH_H) ? WIDTH_A : WIDTH_H;
    localparam logic signed [ACC_W-1:0] HID_MAX = ACC_W'((64'd1 << WIDTH_H) - 64'd1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          i_q, i_d;
    logic [CNT_W-1:0]          n_q, n_d;
    logic [NUM_IN*WIDTH_A-1:0] x_q, x_d;
    logic [WIDTH_H-1:0]        h_q [NUM_HID];
    logic [WIDTH_H-1:0]        h_d [NUM_HID];
    logic signed [ACC_W-1:0]   best_q, best_d;
    logic [OUTWIDTH-1:0]       best_idx_q, best_idx_d;

    logic                      mac_load, mac_en;
    logic signed [ACC_W-1:0]   mac_load_val, mac_sum;
    logic [MAC_AW-1:0]         mac_a;
    logic signed [WIDTH_W-1:0] mac_w;

    int                        w_idx, nb, hb_idx, ob_idx;
    logic signed [WIDTH_B0-1:0] hid_bias;
    logic signed [WIDTH_B1-1:0] out_bias;
    logic signed [ACC_W-1:0]   hid_bias_ext, out_bias_ext, hid_shifted;
    logic [WIDTH_H-1:0]        hid_act;

    mlp_mac #(
        .A_W   (MAC_AW),
        .W_W   (WIDTH_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mac_load),
        .en       (mac_en),
        .load_val (mac_load_val),
        .a        (mac_a),
        .w        (mac_w),
        .sum      (mac_sum)
    );

    // Bias to be loaded next: the following neuron of the current layer, or neuron 0.
    always_comb begin
        nb           = (state_q == StIdle) ? 0 : int'(n_q) + 1;
        hb_idx       = (state_q != StL1 && nb < int'(NUM_HID)) ? nb : 0;
        ob_idx       = (state_q == StL1 && nb < int'(NUM_OUT)) ? nb : 0;
        hid_bias     = biases[hb_idx*WIDTH_B0 +: WIDTH_B0];
        out_bias     = biases[NUM_HID*WIDTH_B0 + ob_idx*WIDTH_B1 +: WIDTH_B1];
        hid_bias_ext = {{(ACC_W - WIDTH_B0){hid_bias[WIDTH_B0-1]}}, hid_bias};
        out_bias_ext = {{(ACC_W - WIDTH_B1){out_bias[WIDTH_B1-1]}}, out_bias};
    end

    always_comb begin
        hid_shifted = mac_sum >>> HID_SHIFT;
        if (mac_sum[ACC_W-1] || mac_sum == '0) begin
            hid_act = '0;
        end else if (hid_shifted > HID_MAX) begin
            hid_act = '1;
        end else begin
            hid_act = hid_shifted[WIDTH_H-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        n_d          = n_q;
        x_d          = x_q;
        h_d          = h_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        mac_load     = 1'b0;
        mac_en       = 1'b0;
        mac_load_val = '0;
        mac_a        = '0;
        mac_w        = '0;
        w_idx        = 0;
        in_ready     = (state_q == StIdle);
        out_valid    = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d          = inp;
                    i_d          = '0;
                    n_d          = '0;
                    mac_load     = 1'b1;
                    mac_load_val = hid_bias_ext;
                    state_d      = StL0;
                end
            end
            StL0: begin
                w_idx                = int'(n_q) * NUM_IN + int'(i_q);
                mac_a[WIDTH_A-1:0]   = x_q[int'(i_q)*WIDTH_A +: WIDTH_A];
                mac_w                = weights[w_idx*WIDTH_W +: WIDTH_W];
                mac_en               = 1'b1;
                if (i_q == CNT_W'(NUM_IN - 1)) begin
                    h_d[n_q] = hid_act;
                    i_d      = '0;
                    mac_load = 1'b1;
                    if (n_q == CNT_W'(NUM_HID - 1)) begin
                        n_d          = '0;
                        mac_load_val = out_bias_ext;
                        state_d      = StL1;
                    end else begin
                        n_d          = n_q + 1'b1;
                        mac_load_val = hid_bias_ext;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StL1: begin
                w_idx                = NUM_IN * NUM_HID + int'(n_q) * NUM_HID + int'(i_q);
                mac_a[WIDTH_H-1:0]   = h_q[i_q];
                mac_w                = weights[w_idx*WIDTH_W +: WIDTH_W];
                mac_en               = 1'b1;
                if (i_q == CNT_W'(NUM_HID - 1)) begin
                    // Strictly greater keeps the lowest index on ties.
                    if (n_q == '0 || mac_sum > best_q) begin
                        best_d     = mac_sum;
                        best_idx_d = OUTWIDTH'(n_q);
                    end
                    i_d = '0;
                    if (n_q == CNT_W'(NUM_OUT - 1)) begin
                        n_d     = '0;
                        state_d = StDone;
                    end else begin
                        n_d          = n_q + 1'b1;
                        mac_load     = 1'b1;
                        mac_load_val = out_bias_ext;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            i_q        <= '0;
            n_q        <= '0;
            x_q        <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            for (int j = 0; j < int'(NUM_HID); j++) begin
                h_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            n_q        <= n_d;
            x_q        <= x_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            h_q        <= h_d;
        end
    end

    assign out       = best_idx_q;
    assign out_score = best_q;

endmodule
